// File: rtl/shift_transmitter.sv
// -----------------------------------------------------------------------------
// shift_transmitter
//
// Parallel-to-serial transmitter. A DATA_WIDTH-bit word is taken over a
// valid/ready handshake and sent one bit per cycle on ser_out. The consumer
// can stall the stream with ser_hold. A word may be dropped at any time with
// abort.
//
// Parameters
//   DATA_WIDTH : word width in bits (>= 2)
//   MSB_FIRST  : 1 sends bit DATA_WIDTH-1 first, 0 sends bit 0 first
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   rst       : synchronous active-high reset
//   in_valid  : producer presents a word on in
//   in_ready  : block accepts a word this cycle
//   in        : parallel word, sampled when in_valid && in_ready
//   abort     : drop the current word and return to IDLE
//   ser_hold  : consumer stall, freezes the serial output
//   ser_out   : current serial bit
//   ser_valid : ser_out carries a valid data bit
//   ser_first : ser_out is the first bit of a word
//   busy      : a word is in flight
//   done      : the last bit of a word is consumed this cycle
//   state_dbg : current FSM state (0 = IDLE, 1 = SHIFT)
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready are
// both high. in_ready never depends on in_valid. in_valid may be raised or
// dropped at will, and in is ignored in every cycle without a transfer. On the
// serial side a bit is consumed in every cycle with ser_valid && !ser_hold.
// -----------------------------------------------------------------------------
module shift_transmitter #(
    parameter int DATA_WIDTH = 16,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in,
    input  logic                  abort,
    input  logic                  ser_hold,
    output logic                  ser_out,
    output logic                  ser_valid,
    output logic                  ser_first,
    output logic                  busy,
    output logic                  done,
    output logic [0:0]            state_dbg
);

    localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_FIRST = CW'(DATA_WIDTH - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]            state;
    logic [DATA_WIDTH-1:0] sh;
    logic [CW-1:0]         cnt;     // bits still to send, minus one

    logic                  take;
    logic                  last_take;
    logic                  accept;
    logic [DATA_WIDTH-1:0] sh_next;

    // A bit leaves the register in every unstalled SHIFT cycle.
    assign take      = (state == SHIFT) && !ser_hold;
    assign last_take = take && (cnt == '0);

    // Ready in IDLE, or while the final bit is taken so that the next word
    // follows without a gap cycle. abort and rst both block acceptance.
    assign in_ready  = !rst && !abort && ((state == IDLE) || last_take);
    assign accept    = in_valid && in_ready;

    assign ser_out   = MSB_FIRST ? sh[DATA_WIDTH-1] : sh[0];
    assign ser_valid = (state == SHIFT);
    assign busy      = (state == SHIFT);
    assign ser_first = (state == SHIFT) && (cnt == CNT_FIRST);
    // A word cut short by rst or abort never signals completion.
    assign done      = last_take && !abort && !rst;
    assign state_dbg = state;

    // Zero-filled shift toward the bit that is sent next.
    always_comb begin
        sh_next = '0;
        if (MSB_FIRST) begin
            sh_next = sh << 1;
        end else begin
            sh_next = sh >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sh    <= '0;
            cnt   <= '0;
        end else if (abort) begin
            state <= IDLE;
            sh    <= '0;
            cnt   <= '0;
        end else if (accept) begin
            // Covers both a load from IDLE and a reload on the final take.
            state <= SHIFT;
            sh    <= in;
            cnt   <= CNT_FIRST;
        end else if (take) begin
            if (cnt == '0) begin
                state <= IDLE;
                sh    <= '0;
            end else begin
                sh  <= sh_next;
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule
